// File: rtl/button_debounce.sv
// Push-button conditioner: per-channel 2-FF synchroniser, counter debounce,
// debounced level plus one-cycle press/release pulses and an aggregate press event.
module button_debounce #(
   parameter int unsigned NUM_BTN         = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_WIDTH       = 20,
   parameter bit          ACTIVE_LOW      = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_i,
   output logic [NUM_BTN-1:0] btn_o,
   output logic [NUM_BTN-1:0] press_o,
   output logic [NUM_BTN-1:0] release_o,
   output logic               evt_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [NUM_BTN-1:0]   POL      = {NUM_BTN{ACTIVE_LOW}};

   logic [NUM_BTN-1:0]   s1;
   logic [NUM_BTN-1:0]   s2;
   logic [CNT_WIDTH-1:0] cnt     [NUM_BTN];
   logic [CNT_WIDTH-1:0] cnt_nxt [NUM_BTN];
   logic [NUM_BTN-1:0]   differ;
   logic [NUM_BTN-1:0]   accept;
   logic [NUM_BTN-1:0]   btn_nxt;
   logic [NUM_BTN-1:0]   press_nxt;
   logic [NUM_BTN-1:0]   release_nxt;

   // Per-channel qualification: any sample equal to the current level restarts the count.
   always_comb begin
      differ = s2 ^ btn_o;
      accept = '0;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
         cnt_nxt[i] = '0;
         accept[i]  = differ[i] && (cnt[i] == CNT_LAST);
         if (differ[i] && !accept[i]) begin
            cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
         end
      end
      btn_nxt     = btn_o ^ accept;
      press_nxt   = accept & s2;
      release_nxt = accept & ~s2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= '0;
         s2        <= '0;
         btn_o     <= '0;
         press_o   <= '0;
         release_o <= '0;
         evt_o     <= 1'b0;
         for (int i = 0; i < int'(NUM_BTN); i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1        <= btn_i ^ POL;
         s2        <= s1;
         btn_o     <= btn_nxt;
         press_o   <= press_nxt;
         release_o <= release_nxt;
         evt_o     <= |press_nxt;
         for (int i = 0; i < int'(NUM_BTN); i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios then random bouncing, checked against
// a sliding-window model (a level is accepted after DC identical synchronised samples).
module tb_button_debounce;

   localparam int unsigned NB = 4;
   localparam int unsigned DC = 4;
   localparam int unsigned CW = 3;
   localparam bit          AL = 1'b0;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_i;
   logic [NB-1:0] btn_o;
   logic [NB-1:0] press_o;
   logic [NB-1:0] release_o;
   logic          evt_o;

   int checks = 0;
   int errors = 0;

   // Model history since the last reset: raw pin samples and what the debouncer sees.
   bit [NB-1:0]   raw_hist[$];
   bit [NB-1:0]   seen_hist[$];
   logic [NB-1:0] want_btn;
   logic [NB-1:0] want_press;
   logic [NB-1:0] want_release;
   logic          want_evt;
   int            hold[NB];

   button_debounce #(
      .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .CNT_WIDTH(CW), .ACTIVE_LOW(AL)
   ) dut (
      .clk(clk), .rst(rst), .btn_i(btn_i), .btn_o(btn_o),
      .press_o(press_o), .release_o(release_o), .evt_o(evt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   // Debouncer at post-reset edge n sees the pin sampled at edge n-2 (zero before that).
   task automatic model_edge();
      int          n;
      bit [NB-1:0] w;
      bit          v;
      bit          stable;
      if (rst) begin
         raw_hist.delete();
         seen_hist.delete();
         want_btn     = '0;
         want_press   = '0;
         want_release = '0;
         want_evt     = 1'b0;
      end else begin
         raw_hist.push_back(btn_i ^ {NB{AL}});
         n = raw_hist.size();
         seen_hist.push_back((n >= 3) ? raw_hist[n-3] : '0);
         want_press   = '0;
         want_release = '0;
         if (seen_hist.size() >= int'(DC)) begin
            for (int ch = 0; ch < int'(NB); ch++) begin
               w      = seen_hist[seen_hist.size()-1];
               v      = w[ch];
               stable = 1'b1;
               for (int j = 0; j < int'(DC); j++) begin
                  w = seen_hist[seen_hist.size()-1-j];
                  if (w[ch] != v) stable = 1'b0;
               end
               if (stable && (v != want_btn[ch])) begin
                  want_btn[ch] = v;
                  if (v) want_press[ch] = 1'b1;
                  else   want_release[ch] = 1'b1;
               end
            end
         end
         want_evt = |want_press;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("btn_o", 32'(btn_o), 32'(want_btn));
      check("press_o", 32'(press_o), 32'(want_press));
      check("release_o", 32'(release_o), 32'(want_release));
      check("evt_o", 32'(evt_o), 32'(want_evt));
      check("press_and_release", 32'(press_o & release_o), 32'(0));
   endtask

   initial begin
      want_btn     = '0;
      want_press   = '0;
      want_release = '0;
      want_evt     = 1'b0;

      // 1: reset with all pins pressed, then release
      rst   = 1'b1;
      btn_i = 4'hF;
      repeat (3) begin
         step();
         check("reset_outputs", 32'({btn_o, press_o, release_o, evt_o}), 32'(0));
      end
      rst = 1'b0;
      repeat (5) begin
         step();
         check("post_reset_quiet", 32'(btn_o), 32'(0));
      end
      step();
      check("post_reset_level", 32'(btn_o), 32'hF);
      check("post_reset_press", 32'(press_o), 32'hF);
      check("post_reset_evt", 32'(evt_o), 32'(1));
      step();
      check("post_reset_press_end", 32'({press_o, evt_o}), 32'(0));

      // 2: clean press on channel 0
      btn_i[0] = 1'b0;
      repeat (7) step();
      btn_i[0] = 1'b1;
      repeat (5) step();
      step();
      check("clean_press_level", 32'(btn_o[0]), 32'(1));
      check("clean_press_pulse", 32'(press_o), 32'h1);
      check("clean_press_evt", 32'(evt_o), 32'(1));
      check("clean_press_no_release", 32'(release_o), 32'(0));
      step();
      check("clean_press_pulse_end", 32'({press_o, evt_o}), 32'(0));

      // 3: bouncing channel 1, then held high
      btn_i[1] = 1'b0;
      repeat (7) step();
      for (int i = 0; i < 20; i++) begin
         btn_i[1] = ((i / 2) % 2) == 0;
         step();
         check("bounce_no_press", 32'(press_o[1]), 32'(0));
      end
      btn_i[1] = 1'b1;
      repeat (5) begin
         step();
         check("bounce_settling", 32'(press_o[1]), 32'(0));
      end
      step();
      check("bounce_single_press", 32'(press_o[1]), 32'(1));

      // 4: release of channel 2
      btn_i[2] = 1'b0;
      repeat (5) step();
      step();
      check("release_level", 32'(btn_o[2]), 32'(0));
      check("release_pulse", 32'(release_o), 32'h4);
      check("release_no_press", 32'({press_o, evt_o}), 32'(0));
      step();
      check("release_pulse_end", 32'(release_o), 32'(0));

      // 5: simultaneous press on channels 0 and 3, then a short glitch on 3
      btn_i[0] = 1'b0;
      btn_i[3] = 1'b0;
      repeat (7) step();
      btn_i[0] = 1'b1;
      btn_i[3] = 1'b1;
      repeat (5) step();
      step();
      check("simul_press", 32'(press_o), 32'b1001);
      check("simul_evt", 32'(evt_o), 32'(1));
      step();
      check("simul_evt_end", 32'(evt_o), 32'(0));
      btn_i[3] = 1'b0;
      repeat (3) step();
      btn_i[3] = 1'b1;
      repeat (8) begin
         step();
         check("glitch_hold", 32'(btn_o[3]), 32'(1));
      end

      // 6: reset while channel 1 is mid-qualification
      btn_i[1] = 1'b0;
      repeat (7) step();
      btn_i[1] = 1'b1;
      repeat (4) step();
      rst = 1'b1;
      repeat (2) begin
         step();
         check("midcount_reset_quiet", 32'({press_o, release_o, evt_o}), 32'(0));
      end
      rst = 1'b0;
      repeat (5) begin
         step();
         check("requalify_wait", 32'(press_o[1]), 32'(0));
      end
      step();
      check("requalify_press", 32'(press_o[1]), 32'(1));

      // Random bouncing with occasional resets
      for (int ch = 0; ch < int'(NB); ch++) hold[ch] = $urandom_range(1, 8);
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int ch = 0; ch < int'(NB); ch++) begin
            if (hold[ch] == 0) begin
               btn_i[ch] = ~btn_i[ch];
               hold[ch]  = $urandom_range(1, 8);
            end else begin
               hold[ch]--;
            end
         end
         step();
      end
      rst = 1'b0;
      repeat (8) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
